bus_command_controller: RTL and testbench

- Cycle-accurate bus controller that decodes the CPU's three status lines into the system bus command strobes consumed by the chipset: I/O and memory read/write, advanced writes, and interrupt acknowledge.
- Also generates ALE, DEN and DT/R.
- Sits directly upstream of the chipset bus interface, replacing a discrete 8288.
- Inserts programmable I/O wait states and yields the bus when address_enable_n indicates DMA ownership.

---
 rtl/bus_command_controller.sv | 161 ++++++++++++++++
 tb/tb_bus_command_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_command_controller.sv
// Bus command controller: decodes CPU S2..S0 into registered bus strobes,
// with programmable minimum wait states and a DMA bus-yield path.
module bus_command_controller #(
    parameter int unsigned io_wait_states  = 1,
    parameter int unsigned mem_wait_states = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] status_n,
    input  logic       ready,
    input  logic       address_enable_n,
    output logic       address_latch_enable,
    output logic       data_enable,
    output logic       data_transmit_receive_n,
    output logic       io_read_command_n,
    output logic       io_write_command_n,
    output logic       advanced_io_write_command_n,
    output logic       memory_read_command_n,
    output logic       memory_write_command_n,
    output logic       advanced_memory_write_command_n,
    output logic       interrupt_acknowledge_n,
    output logic [2:0] bus_cycle_type,
    output logic       bus_busy
);

    localparam logic [2:0] ST_INTA = 3'b000;
    localparam logic [2:0] ST_IOR  = 3'b001;
    localparam logic [2:0] ST_IOW  = 3'b010;
    localparam logic [2:0] ST_HALT = 3'b011;
    localparam logic [2:0] ST_CODE = 3'b100;
    localparam logic [2:0] ST_MEMR = 3'b101;
    localparam logic [2:0] ST_MEMW = 3'b110;
    localparam logic [2:0] ST_PASV = 3'b111;

    localparam logic [2:0] IO_WAIT  = 3'(io_wait_states);
    localparam logic [2:0] MEM_WAIT = 3'(mem_wait_states);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_T3,
        S_T4
    } state_t;

    state_t     r_state;
    logic       r_passive_seen;
    logic [2:0] r_wait_cnt;
    logic       w_start;
    logic [2:0] w_wait_load;

    assign w_start = (status_n != ST_PASV) && (status_n != ST_HALT)
                   && r_passive_seen && !address_enable_n;

    always_comb begin
        w_wait_load = 3'd0;
        if (status_n == ST_IOR || status_n == ST_IOW)
            w_wait_load = IO_WAIT;
        else if (status_n[2])
            w_wait_load = MEM_WAIT;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state                         <= S_IDLE;
            r_passive_seen                  <= 1'b0;
            r_wait_cnt                      <= 3'd0;
            address_latch_enable            <= 1'b0;
            data_enable                     <= 1'b0;
            data_transmit_receive_n         <= 1'b1;
            io_read_command_n               <= 1'b1;
            io_write_command_n              <= 1'b1;
            advanced_io_write_command_n     <= 1'b1;
            memory_read_command_n           <= 1'b1;
            memory_write_command_n          <= 1'b1;
            advanced_memory_write_command_n <= 1'b1;
            interrupt_acknowledge_n         <= 1'b1;
            bus_cycle_type                  <= ST_PASV;
            bus_busy                        <= 1'b0;
        end else begin
            if (status_n == ST_PASV)
                r_passive_seen <= 1'b1;

            if (r_state != S_IDLE && address_enable_n) begin
                // DMA owns the bus: drop every strobe immediately
                r_state                         <= S_IDLE;
                bus_busy                        <= 1'b0;
                address_latch_enable            <= 1'b0;
                data_enable                     <= 1'b0;
                data_transmit_receive_n         <= 1'b1;
                io_read_command_n               <= 1'b1;
                io_write_command_n              <= 1'b1;
                advanced_io_write_command_n     <= 1'b1;
                memory_read_command_n           <= 1'b1;
                memory_write_command_n          <= 1'b1;
                advanced_memory_write_command_n <= 1'b1;
                interrupt_acknowledge_n         <= 1'b1;
            end else begin
                unique case (r_state)
                    S_IDLE, S_T4: begin
                        address_latch_enable    <= 1'b0;
                        data_enable             <= 1'b0;
                        data_transmit_receive_n <= 1'b1;
                        if (w_start) begin
                            r_state                 <= S_T1;
                            r_passive_seen          <= 1'b0;
                            r_wait_cnt              <= w_wait_load;
                            bus_cycle_type          <= status_n;
                            bus_busy                <= 1'b1;
                            address_latch_enable    <= 1'b1;
                            // reads and INTA all have S1 = 0
                            data_transmit_receive_n <= status_n[1];
                        end else begin
                            r_state  <= S_IDLE;
                            bus_busy <= 1'b0;
                        end
                    end
                    S_T1: begin
                        r_state              <= S_T2;
                        address_latch_enable <= 1'b0;
                        data_enable          <= 1'b1;
                        unique case (bus_cycle_type)
                            ST_INTA: interrupt_acknowledge_n <= 1'b0;
                            ST_IOR:  io_read_command_n <= 1'b0;
                            ST_IOW:  advanced_io_write_command_n <= 1'b0;
                            ST_CODE,
                            ST_MEMR: memory_read_command_n <= 1'b0;
                            ST_MEMW: advanced_memory_write_command_n <= 1'b0;
                            default: ;
                        endcase
                    end
                    S_T2: begin
                        r_state <= S_T3;
                        if (bus_cycle_type == ST_IOW)
                            io_write_command_n <= 1'b0;
                        if (bus_cycle_type == ST_MEMW)
                            memory_write_command_n <= 1'b0;
                    end
                    S_T3: begin
                        if (r_wait_cnt != 3'd0) begin
                            r_wait_cnt <= r_wait_cnt - 3'd1;
                        end else if (ready) begin
                            r_state                         <= S_T4;
                            data_enable                     <= 1'b0;
                            data_transmit_receive_n         <= 1'b1;
                            io_read_command_n               <= 1'b1;
                            io_write_command_n              <= 1'b1;
                            advanced_io_write_command_n     <= 1'b1;
                            memory_read_command_n           <= 1'b1;
                            memory_write_command_n          <= 1'b1;
                            advanced_memory_write_command_n <= 1'b1;
                            interrupt_acknowledge_n         <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bus_command_controller.sv
// Bench for bus_command_controller: vector table, directed corner sequences
// and random traffic against a bus-cycle-level reference model.
module tb_bus_command_controller;

    localparam int IO_W  = 1;
    localparam int MEM_W = 0;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] status_n = 3'b111;
    logic       ready = 1'b1;
    logic       aen_n = 1'b0;
    logic       ale, den, dtr, ior, iow, aiow, mr, mw, amw, inta, busy;
    logic [2:0] bct;

    bus_command_controller #(
        .io_wait_states (IO_W),
        .mem_wait_states(MEM_W)
    ) dut (
        .clock                          (clock),
        .reset                          (reset),
        .status_n                       (status_n),
        .ready                          (ready),
        .address_enable_n               (aen_n),
        .address_latch_enable           (ale),
        .data_enable                    (den),
        .data_transmit_receive_n        (dtr),
        .io_read_command_n              (ior),
        .io_write_command_n             (iow),
        .advanced_io_write_command_n    (aiow),
        .memory_read_command_n          (mr),
        .memory_write_command_n         (mw),
        .advanced_memory_write_command_n(amw),
        .interrupt_acknowledge_n        (inta),
        .bus_cycle_type                 (bct),
        .bus_busy                       (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Reference model: one bus cycle described by its age since T1
    bit       m_active, m_t4, m_ps;
    int       m_age, m_waits;
    bit [2:0] m_typ = 3'b111;

    int n_ale, n_ior, n_iow, n_aiow, n_mr, n_mw, n_inta, inta_pulses;
    int cyc, last_iow, last_aiow;
    bit prev_inta = 1'b1;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int wait_for(input bit [2:0] t);
        if (t == 3'd1 || t == 3'd2) return IO_W;
        if (t == 3'd0) return 0;
        return MEM_W;
    endfunction

    task automatic model_edge(input bit [2:0] st, input bit rdy,
                              input bit aen, input bit rst);
        bit start;
        bit ps_next;
        if (rst) begin
            m_active = 0; m_t4 = 0; m_ps = 0; m_age = 0; m_waits = 0;
            m_typ = 3'b111;
            return;
        end
        ps_next = m_ps | (st == 3'b111);
        start = (st != 3'b111) && (st != 3'b011) && m_ps && !aen;
        if (m_active && aen) begin
            m_active = 0;
            m_t4 = 0;
        end else if (!m_active || m_t4) begin
            m_t4 = 0;
            m_active = start;
            if (start) begin
                m_typ = st;
                m_age = 0;
                m_waits = wait_for(st);
                ps_next = 0;
            end
        end else if (m_age < 2) begin
            m_age++;
        end else if (m_waits > 0) begin
            m_waits--;
        end else if (rdy) begin
            m_t4 = 1;
        end
        m_ps = ps_next;
    endtask

    function automatic logic [13:0] model_vec();
        bit l2, l3;
        l2 = m_active && !m_t4 && m_age >= 1;
        l3 = m_active && !m_t4 && m_age >= 2;
        return {m_active && !m_t4 && m_age == 0,
                l2,
                !(m_active && !m_t4 && !m_typ[1]),
                !(l2 && m_typ == 3'd1),
                !(l3 && m_typ == 3'd2),
                !(l2 && m_typ == 3'd2),
                !(l2 && (m_typ == 3'd4 || m_typ == 3'd5)),
                !(l3 && m_typ == 3'd6),
                !(l2 && m_typ == 3'd6),
                !(l2 && m_typ == 3'd0),
                m_typ,
                m_active};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {ale, den, dtr, ior, iow, aiow, mr, mw, amw, inta, bct, busy};
    endfunction

    task automatic clear_counts();
        n_ale = 0; n_ior = 0; n_iow = 0; n_aiow = 0; n_mr = 0; n_mw = 0;
        n_inta = 0; inta_pulses = 0; last_iow = -1; last_aiow = -1;
    endtask

    task automatic step(input bit [2:0] st, input bit rdy, input bit aen,
                        input bit rst);
        status_n = st; ready = rdy; aen_n = aen; reset = rst;
        @(posedge clock);
        model_edge(st, rdy, aen, rst);
        #1;
        cyc++;
        check("model", dut_vec(), model_vec());
        if (ale) n_ale++;
        if (!ior) n_ior++;
        if (!iow) begin n_iow++; last_iow = cyc; end
        if (!aiow) begin n_aiow++; last_aiow = cyc; end
        if (!mr) n_mr++;
        if (!mw) n_mw++;
        if (!inta) n_inta++;
        if (prev_inta && !inta) inta_pulses++;
        prev_inta = inta;
    endtask

    typedef struct {
        bit [2:0] st;
        bit       rdy, aen, rst;
        bit       e_ale, e_den, e_dtr, e_mr, e_busy;
        bit [2:0] e_bct;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{3'd7, 1, 0, 1, 0, 0, 1, 1, 0, 3'd7};
        tbl[1] = '{3'd7, 1, 0, 0, 0, 0, 1, 1, 0, 3'd7};
        tbl[2] = '{3'd7, 1, 0, 0, 0, 0, 1, 1, 0, 3'd7};
        tbl[3] = '{3'd5, 1, 0, 0, 1, 0, 0, 1, 1, 3'd5};
        tbl[4] = '{3'd5, 1, 0, 0, 0, 1, 0, 0, 1, 3'd5};
        tbl[5] = '{3'd7, 1, 0, 0, 0, 1, 0, 0, 1, 3'd5};
        tbl[6] = '{3'd7, 1, 0, 0, 0, 0, 1, 1, 1, 3'd5};
        tbl[7] = '{3'd7, 1, 0, 0, 0, 0, 1, 1, 0, 3'd5};
        cyc = 0;
        clear_counts();

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].st, tbl[i].rdy, tbl[i].aen, tbl[i].rst);
            check($sformatf("tbl_row%0d", i),
                  {ale, den, dtr, mr, busy, bct},
                  {tbl[i].e_ale, tbl[i].e_den, tbl[i].e_dtr, tbl[i].e_mr,
                   tbl[i].e_busy, tbl[i].e_bct});
        end
        check("memr_width", n_mr, 2);
        check("memr_ale", n_ale, 1);

        // I/O write with one forced wait state
        clear_counts();
        step(3'd7, 1, 0, 0);
        step(3'd2, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(3'd7, 1, 0, 0);
        check("iow_adv_width", n_aiow, 3);
        check("iow_width", n_iow, 2);
        check("iow_same_rise", last_iow, last_aiow);

        // I/O read stretched by four not-ready cycles
        clear_counts();
        step(3'd7, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(3'd1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(3'd7, 0, 0, 0);
        step(3'd7, 1, 0, 0);
        check("ior_after_ready", ior, 1'b1);
        step(3'd7, 1, 0, 0);
        check("ior_width", n_ior, 7);

        // Two INTA cycles separated by a passive status
        clear_counts();
        step(3'd7, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(3'd0, 1, 0, 0);
        step(3'd7, 1, 0, 0);
        for (int i = 0; i < 8; i++) step(3'd0, 1, 0, 0);
        check("inta_pulses2", inta_pulses, 2);
        check("inta_width2", n_inta, 4);

        // INTA held without passive gives only one pulse
        clear_counts();
        step(3'd7, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(3'd0, 1, 0, 0);
        check("inta_pulses1", inta_pulses, 1);
        check("inta_width1", n_inta, 2);

        // DMA takes the bus during TW of a memory write
        clear_counts();
        step(3'd7, 1, 0, 0);
        step(3'd6, 1, 0, 0);
        step(3'd6, 1, 0, 0);
        step(3'd6, 0, 0, 0);
        step(3'd6, 0, 0, 0);
        check("dma_mw_low", mw, 1'b0);
        step(3'd7, 0, 1, 0);
        check("dma_strobes", {mw, amw, den, ale, busy}, 5'b11000);
        clear_counts();
        step(3'd7, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(3'd6, 1, 1, 0);
        check("dma_no_ale", n_ale, 0);
        check("dma_no_busy", busy, 1'b0);
        step(3'd7, 1, 0, 0);

        // HALT never starts a cycle
        clear_counts();
        step(3'd7, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(3'd3, 1, 0, 0);
        check("halt_no_ale", n_ale, 0);
        check("halt_no_busy", busy, 1'b0);
        step(3'd7, 1, 0, 0);

        // Reset during T2 of an I/O read
        step(3'd1, 1, 0, 0);
        step(3'd1, 1, 0, 0);
        check("rst_ior_low", ior, 1'b0);
        step(3'd1, 1, 0, 1);
        check("rst_ior_high", {ior, busy, bct}, {1'b1, 1'b0, 3'b111});
        step(3'd7, 1, 0, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bit [2:0] st;
            st = ($urandom_range(0, 2) == 0) ? 3'd7 : 3'($urandom_range(0, 7));
            step(st, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 99) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
